// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, RGB565 colours and pixel type for the
// VGA timing stage and the renderer.
package vga_pkg;

  typedef logic [15:0] pixel_t;

  localparam logic [9:0] VGA_H_SYNC  = 10'd96;
  localparam logic [9:0] VGA_H_BACK  = 10'd48;
  localparam logic [9:0] VGA_H_DISP  = 10'd640;
  localparam logic [9:0] VGA_H_FRONT = 10'd16;
  localparam logic [9:0] VGA_H_TOTAL = 10'd800;

  localparam logic [9:0] VGA_V_SYNC  = 10'd2;
  localparam logic [9:0] VGA_V_BACK  = 10'd33;
  localparam logic [9:0] VGA_V_DISP  = 10'd480;
  localparam logic [9:0] VGA_V_FRONT = 10'd10;
  localparam logic [9:0] VGA_V_TOTAL = 10'd525;

  localparam logic       VGA_SYNC_POL = 1'b0;

  localparam logic [9:0] BAR_WIDTH = 10'd80;

  localparam pixel_t WHITE   = 16'hFFFF;
  localparam pixel_t YELLOW  = 16'hFFE0;
  localparam pixel_t CYAN    = 16'h07FF;
  localparam pixel_t GREEN   = 16'h07E0;
  localparam pixel_t MAGENTA = 16'hF81F;
  localparam pixel_t RED     = 16'hF800;
  localparam pixel_t BLUE    = 16'h001F;
  localparam pixel_t BLACK   = 16'h0000;

endpackage

// File: rtl/vga_color_bar.sv
// Active-column to colour lookup for the eight-bar test pattern
// (only instantiated when VGA_TEST_PATTERN_EN is defined).
module vga_color_bar
  import vga_pkg::*;
(
  input  logic [9:0] col,
  output pixel_t     rgb
);

  // Threshold chain instead of col/80 keeps this a plain comparator ladder.
  always_comb begin
    rgb = BLACK;
    if (col < BAR_WIDTH * 10'd1)      rgb = WHITE;
    else if (col < BAR_WIDTH * 10'd2) rgb = YELLOW;
    else if (col < BAR_WIDTH * 10'd3) rgb = CYAN;
    else if (col < BAR_WIDTH * 10'd4) rgb = GREEN;
    else if (col < BAR_WIDTH * 10'd5) rgb = MAGENTA;
    else if (col < BAR_WIDTH * 10'd6) rgb = RED;
    else if (col < BAR_WIDTH * 10'd7) rgb = BLUE;
    else                              rgb = BLACK;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: sync, active window, one-clock-early pixel requests
// and output gating. Optional colour-bar test pattern under VGA_TEST_PATTERN_EN.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter logic [9:0] H_SYNC   = VGA_H_SYNC,
  parameter logic [9:0] H_BACK   = VGA_H_BACK,
  parameter logic [9:0] H_DISP   = VGA_H_DISP,
  parameter logic [9:0] H_FRONT  = VGA_H_FRONT,
  parameter logic [9:0] H_TOTAL  = VGA_H_TOTAL,
  parameter logic [9:0] V_SYNC   = VGA_V_SYNC,
  parameter logic [9:0] V_BACK   = VGA_V_BACK,
  parameter logic [9:0] V_DISP   = VGA_V_DISP,
  parameter logic [9:0] V_FRONT  = VGA_V_FRONT,
  parameter logic [9:0] V_TOTAL  = VGA_V_TOTAL,
  parameter logic       SYNC_POL = VGA_SYNC_POL
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       test_mode,
`endif
  input  pixel_t     pixel_data,
  output logic [9:0] pixel_xpos,
  output logic [9:0] pixel_ypos,
  output logic       data_req,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_en,
  output pixel_t     vga_rgb,
  output logic       frame_start
);

  localparam logic [9:0] HA    = H_SYNC + H_BACK;
  localparam logic [9:0] VA    = V_SYNC + V_BACK;
  localparam logic [9:0] H_END = HA + H_DISP;
  localparam logic [9:0] V_END = VA + V_DISP;

  if (H_SYNC + H_BACK + H_DISP + H_FRONT != H_TOTAL) begin : g_bad_h_total
    $error("vga_timing_gen: horizontal segments do not sum to H_TOTAL");
  end
  if (V_SYNC + V_BACK + V_DISP + V_FRONT != V_TOTAL) begin : g_bad_v_total
    $error("vga_timing_gen: vertical segments do not sum to V_TOTAL");
  end

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_last;
  logic       v_last;
  logic       h_active;
  logic       h_req;
  logic       v_active;

  assign h_last = (h_cnt == H_TOTAL - 10'd1);
  assign v_last = (v_cnt == V_TOTAL - 10'd1);

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + 10'd1;
      if (h_last) begin
        v_cnt <= v_last ? '0 : v_cnt + 10'd1;
      end
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  assign vga_hs = (h_cnt < H_SYNC) ? SYNC_POL : ~SYNC_POL;
  assign vga_vs = (v_cnt < V_SYNC) ? SYNC_POL : ~SYNC_POL;

  assign h_active = (h_cnt >= HA) && (h_cnt < H_END);
  assign v_active = (v_cnt >= VA) && (v_cnt < V_END);
  // Requests lead the active window by one clock to cover the renderer's register.
  assign h_req    = (h_cnt >= HA - 10'd1) && (h_cnt < H_END - 10'd1);

  assign vga_en   = h_active && v_active;
  assign data_req = h_req && v_active;

  assign pixel_xpos = data_req ? (h_cnt - (HA - 10'd1)) : '0;
  assign pixel_ypos = data_req ? (v_cnt - VA) : '0;

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0] active_col;
  pixel_t     bar_rgb;

  assign active_col = h_cnt - HA;

  vga_color_bar u_color_bar (
    .col (active_col),
    .rgb (bar_rgb)
  );
`endif

  always_comb begin
    vga_rgb = BLACK;
    if (vga_en) begin
`ifdef VGA_TEST_PATTERN_EN
      vga_rgb = test_mode ? bar_rgb : pixel_data;
`else
      vga_rgb = pixel_data;
`endif
    end
  end

endmodule
